// File: rtl/reg_port_arbiter.sv
// Shares the reg_file's single address-1 port between two writeback sources and an operand reader.
// Clears every register after reset, suppresses r0 writes, and bounds read starvation.
module reg_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int R0_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wa_valid,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  output logic              wa_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_ready,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic [ADDR_W-1:0] reg_addr1,
  output logic [ADDR_W-1:0] reg_addr2,
  output logic [DATA_W-1:0] reg_din,
  output logic              reg_wr,
  input  logic [DATA_W-1:0] reg_out_1,
  input  logic [DATA_W-1:0] reg_out_2,
  output logic              busy,
  output logic              dbg_run
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  // Handshake: a requester holds valid/addr/data stable until its ready is 1;
  // the transfer happens in the cycle where valid and ready are both 1.
  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [3:0]          starve_cnt;
  logic                last_b;
  logic                rd_vld_q;
  logic [DATA_W-1:0]   rd_q1;
  logic [DATA_W-1:0]   rd_q2;

  logic                run;
  logic                any_w;
  logic                starved;
  logic                rd_win;
  logic                w_win;
  logic                pick_b;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;

  assign run     = (state == S_RUN) && !rst;
  assign any_w   = wa_valid || wb_valid;
  assign starved = (starve_cnt == 4'(STARVE_LIMIT));
  assign rd_win  = run && rd_valid && (!any_w || starved);
  assign w_win   = run && any_w && !rd_win;
  // With both writers valid, the one that did not win last time goes next.
  assign pick_b  = wb_valid && (!wa_valid || !last_b);
  assign w_addr  = pick_b ? wb_addr : wa_addr;
  assign w_data  = pick_b ? wb_data : wa_data;

  assign wa_ready = w_win && !pick_b;
  assign wb_ready = w_win && pick_b;
  assign rd_ready = rd_win;

  always_comb begin
    reg_wr    = 1'b0;
    reg_addr1 = '0;
    reg_addr2 = rd_addr2;
    reg_din   = '0;
    if (state == S_CLEAR) begin
      reg_wr    = !rst;
      reg_addr1 = clr_idx;
      reg_addr2 = '0;
    end else if (w_win) begin
      reg_addr1 = w_addr;
      reg_din   = w_data;
      reg_wr    = !((R0_HARDWIRED != 0) && (w_addr == '0));
    end else if (rd_win) begin
      reg_addr1 = rd_addr1;
    end
  end

  assign busy          = rst || (state == S_CLEAR);
  assign dbg_run       = (state == S_RUN);
  assign rd_data_valid = rd_vld_q && !rst;
  assign rd_data_1     = rst ? '0 : rd_q1;
  assign rd_data_2     = rst ? '0 : rd_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLEAR;
      clr_idx    <= '0;
      starve_cnt <= '0;
      last_b     <= 1'b1;
      rd_vld_q   <= 1'b0;
      rd_q1      <= '0;
      rd_q2      <= '0;
    end else begin
      rd_vld_q <= rd_win;
      if (rd_win) begin
        rd_q1 <= reg_out_1;
        rd_q2 <= reg_out_2;
      end
      case (state)
        S_CLEAR: begin
          clr_idx    <= clr_idx + 1'b1;
          starve_cnt <= '0;
          if (clr_idx == ADDR_W'(NUM_REGS - 1)) state <= S_RUN;
        end
        S_RUN: begin
          if (w_win) last_b <= pick_b;
          if (w_win && rd_valid)
            starve_cnt <= starved ? starve_cnt : starve_cnt + 4'd1;
          else
            starve_cnt <= '0;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
